// File: rtl/ddfs_sweep_ctrl.sv
// Frequency-sweep controller and phase accumulator for a DDFS.
// Optional macro DDFS_PHASE_RESET_EN zeroes the phase accumulator when a sweep starts.
module ddfs_sweep_ctrl #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [ACC_W-1:0] cfg_fcw_start,
    input  logic [ACC_W-1:0] cfg_fcw_step,
    input  logic [CNT_W-1:0] cfg_dwell,
    input  logic [CNT_W-1:0] cfg_steps,
    input  logic             start,
    input  logic             abort,
    input  logic             pa_en,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] fcw,
    output logic [ACC_W-1:0] PA_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] fcw_q, fcw_d;
    logic [ACC_W-1:0] pa_q, pa_d;
    logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

    logic [ACC_W-1:0] sh_start_q, sh_step_q;
    logic [CNT_W-1:0] sh_dwell_q, sh_steps_q;
    logic             cfg_loaded_q;

    // Working copies: the shadow may be rewritten on the very cycle a sweep starts.
    logic [ACC_W-1:0] act_step_q, act_step_d;
    logic [CNT_W-1:0] act_dwell_q, act_dwell_d;

    logic             cfg_accept;

    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    assign cfg_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign fcw        = fcw_q;
    assign PA_out     = pa_q;
    assign cfg_accept = cfg_valid && cfg_ready;

    always_comb begin
        state_d     = state_q;
        fcw_d       = fcw_q;
        dwell_cnt_d = dwell_cnt_q;
        step_cnt_d  = step_cnt_q;
        act_step_d  = act_step_q;
        act_dwell_d = act_dwell_q;
        pa_d        = pa_q;

        unique case (state_q)
            IDLE: begin
                if (start && cfg_loaded_q && !abort) begin
                    state_d     = SWEEP;
                    fcw_d       = sh_start_q;
                    act_step_d  = sh_step_q;
                    act_dwell_d = at_least_one(sh_dwell_q);
                    dwell_cnt_d = at_least_one(sh_dwell_q);
                    step_cnt_d  = at_least_one(sh_steps_q);
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (dwell_cnt_q == CNT_W'(1)) begin
                    if (step_cnt_q > CNT_W'(1)) begin
                        fcw_d       = fcw_q + act_step_q;
                        step_cnt_d  = step_cnt_q - CNT_W'(1);
                        dwell_cnt_d = act_dwell_q;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pa_en) begin
            pa_d = pa_q + fcw_q;
        end
`ifdef DDFS_PHASE_RESET_EN
        if ((state_q == IDLE) && (state_d == SWEEP)) begin
            pa_d = '0;
        end
`else
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fcw_q       <= '0;
            pa_q        <= '0;
            dwell_cnt_q <= '0;
            step_cnt_q  <= '0;
            act_step_q  <= '0;
            act_dwell_q <= '0;
        end else begin
            state_q     <= state_d;
            fcw_q       <= fcw_d;
            pa_q        <= pa_d;
            dwell_cnt_q <= dwell_cnt_d;
            step_cnt_q  <= step_cnt_d;
            act_step_q  <= act_step_d;
            act_dwell_q <= act_dwell_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_start_q   <= '0;
            sh_step_q    <= '0;
            sh_dwell_q   <= '0;
            sh_steps_q   <= '0;
            cfg_loaded_q <= 1'b0;
        end else if (cfg_accept) begin
            sh_start_q   <= cfg_fcw_start;
            sh_step_q    <= cfg_fcw_step;
            sh_dwell_q   <= cfg_dwell;
            sh_steps_q   <= cfg_steps;
            cfg_loaded_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// Directed bench for ddfs_sweep_ctrl; expected FCW sequences are queued when a sweep is started.
module tb_ddfs_sweep_ctrl;
    localparam int ACC_W = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             pa_en = 1'b0;
    logic [ACC_W-1:0] cfg_fcw_start = '0;
    logic [ACC_W-1:0] cfg_fcw_step = '0;
    logic [CNT_W-1:0] cfg_dwell = '0;
    logic [CNT_W-1:0] cfg_steps = '0;
    logic             cfg_ready, busy, done;
    logic [ACC_W-1:0] fcw, PA_out;

    int               n_tests = 0;
    int               n_fail = 0;
    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] pa_m;

    always #5 clk = ~clk;

    ddfs_sweep_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_fcw_start(cfg_fcw_start), .cfg_fcw_step(cfg_fcw_step),
        .cfg_dwell(cfg_dwell), .cfg_steps(cfg_steps),
        .start(start), .abort(abort), .pa_en(pa_en),
        .busy(busy), .done(done), .fcw(fcw), .PA_out(PA_out)
    );

    task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [ACC_W-1:0] s, input logic [ACC_W-1:0] st,
                            input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] n);
        cfg_valid = 1'b1;
        cfg_fcw_start = s;
        cfg_fcw_step = st;
        cfg_dwell = d;
        cfg_steps = n;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic push_sweep(input logic [ACC_W-1:0] s, input logic [ACC_W-1:0] st,
                              input int d, input int n);
        int               dd;
        int               nn;
        logic [ACC_W-1:0] v;
        dd = (d == 0) ? 1 : d;
        nn = (n == 0) ? 1 : n;
        v = s;
        for (int k = 0; k < nn; k++) begin
            for (int j = 0; j < dd; j++) exp_q.push_back(v);
            v = v + st;
        end
    endtask

    // Called on the first SWEEP cycle; consumes the queue, then checks DONE and the return to IDLE.
    task automatic check_sweep(input string tag, input bit inject);
        int               n;
        logic [ACC_W-1:0] last;
        n = exp_q.size();
        last = '0;
        for (int i = 0; i < n; i++) begin
            last = exp_q.pop_front();
            chk({tag, "_fcw"}, fcw, last);
            chkb({tag, "_busy"}, busy, 1'b1);
            chkb({tag, "_nodone"}, done, 1'b0);
            if (inject && i == 0) begin
                cfg_valid = 1'b1;
                cfg_fcw_start = 32'hDEAD_0000;
                cfg_fcw_step = 32'h5;
                cfg_dwell = 16'd7;
                cfg_steps = 16'd9;
                start = 1'b1;
                chkb({tag, "_rdy_low"}, cfg_ready, 1'b0);
            end
            if (inject && i == 1) begin
                cfg_valid = 1'b0;
                start = 1'b0;
            end
            tick();
        end
        chkb({tag, "_done"}, done, 1'b1);
        chk({tag, "_fcw_done"}, fcw, last);
        tick();
        chkb({tag, "_done_clr"}, done, 1'b0);
        chkb({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_fcw_hold"}, fcw, last);
    endtask

    initial begin
        // Reset values
        #1 rst = 1'b1;
        #1;
        chk("rst_fcw", fcw, '0);
        chk("rst_pa", PA_out, '0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_done", done, 1'b0);
        chkb("rst_ready", cfg_ready, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Start without any configuration is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chkb("nocfg_busy", busy, 1'b0);
        tick();
        chkb("nocfg_busy2", busy, 1'b0);

        // Basic sweep, with cfg and start offered mid-sweep
        load_cfg(32'h1000, 32'h100, 16'd3, 16'd4);
        start = 1'b1;
        push_sweep(32'h1000, 32'h100, 3, 4);
        tick();
        start = 1'b0;
        check_sweep("sw1", 1'b1);

        // New cfg coincident with start: old shadow drives this sweep
        cfg_valid = 1'b1;
        cfg_fcw_start = 32'h2000;
        cfg_fcw_step = 32'hFFFF_FFF0;
        cfg_dwell = 16'd1;
        cfg_steps = 16'd3;
        start = 1'b1;
        push_sweep(32'h1000, 32'h100, 3, 4);
        tick();
        cfg_valid = 1'b0;
        start = 1'b0;
        check_sweep("sw2", 1'b0);

        // The captured config, with a negative step
        start = 1'b1;
        push_sweep(32'h2000, 32'hFFFF_FFF0, 1, 3);
        tick();
        start = 1'b0;
        check_sweep("sw3", 1'b0);

        // Abort in the second dwell cycle of step 2
        load_cfg(32'h1000, 32'h100, 16'd3, 16'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("ab_pre_fcw", fcw, 32'h1100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chkb("ab_busy", busy, 1'b0);
        chkb("ab_done", done, 1'b0);
        chkb("ab_ready", cfg_ready, 1'b1);
        chk("ab_fcw", fcw, 32'h1100);
        tick();
        chkb("ab_done2", done, 1'b0);
        chk("ab_fcw2", fcw, 32'h1100);

        // Zero dwell and zero steps collapse to one cycle
        load_cfg(32'h55, 32'h7, 16'd0, 16'd0);
        start = 1'b1;
        push_sweep(32'h55, 32'h7, 0, 0);
        tick();
        start = 1'b0;
        check_sweep("zero", 1'b0);

        // Accumulator wrap with fcw = 0x4000_0000
        load_cfg(32'h4000_0000, 32'h0, 16'd20, 16'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("pa_init", PA_out, '0);
        pa_m = '0;
        pa_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            pa_m = pa_m + 32'h4000_0000;
            chk($sformatf("pa_acc%0d", k), PA_out, pa_m);
        end
        chk("pa_wrap_val", pa_m, 32'h4000_0000);
        pa_en = 1'b0;
        tick();
        chk("pa_hold", PA_out, pa_m);

        // Asynchronous reset between edges, mid-sweep
        #3 rst = 1'b1;
        #1;
        chk("arst_fcw", fcw, '0);
        chk("arst_pa", PA_out, '0);
        chkb("arst_busy", busy, 1'b0);
        chkb("arst_done", done, 1'b0);
        chkb("arst_ready", cfg_ready, 1'b1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chkb("arst_nodone", done, 1'b0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chkb("arst_cfgclr", busy, 1'b0);

        // Phase behaviour at sweep entry
        load_cfg(32'h10, 32'h0, 16'd1, 16'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("ph_fcw_held", fcw, 32'h10);
        pa_en = 1'b1;
        tick();
        tick();
        tick();
        chk("ph_pa30", PA_out, 32'h30);
        load_cfg(32'h100, 32'h0, 16'd2, 16'd1);
        chk("ph_pa40", PA_out, 32'h40);
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef DDFS_PHASE_RESET_EN
        pa_m = 32'h0;
`else
        pa_m = 32'h50;
`endif
        chk("ph_entry", PA_out, pa_m);
        chk("ph_fcw", fcw, 32'h100);
        tick();
        chk("ph_next", PA_out, pa_m + 32'h100);
        pa_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
